pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generation stage, directly upstream of the instruction fetch unit.
- Holds the architectural PC and presents it to fetch over a valid/ready handshake.
- Waits for the writeback stage to commit the issued instruction, then computes the next PC: sequential, branch/jump redirect, or trap vector.
- Multicycle, one instruction in flight; also provides a hang watchdog and an issue counter for the simulation harness.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before hang asserts; 0 disables the watchdog.
- CNT_W, 32, width of the issue counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- ifu_valid  output  1  PC on ifu_pc is valid for fetch.
- ifu_ready  input  1  fetch accepts ifu_pc this cycle.
- ifu_pc  output  32  PC to fetch.
- wb_valid  input  1  writeback commits the issued instruction (1-cycle pulse).
- wb_redirect  input  1  committed instruction is a taken branch/jump/mret.
- wb_target  input  32  redirect target, sampled when wb_valid && wb_redirect.
- trap_valid  input  1  committed instruction raised a trap; sampled with wb_valid.
- trap_vec  input  32  trap vector (mtvec), sampled with trap_valid.
- halt  input  1  committed instruction is ebreak; sampled with wb_valid.
- hang  output  1  sticky watchdog flag.
- misalign  output  1  sticky misaligned-target flag; tied 0 without the optional feature.
- issue_cnt  output  CNT_W  number of accepted fetch handshakes.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=BOOT, pc_q=RESET_PC.
  - ifu_valid=0, hang=0, misalign=0, issue_cnt=0, watchdog count=0.
- States: BOOT, ISSUE, WAIT, HALT.
- BOOT: ifu_valid=0; unconditionally moves to ISSUE next cycle. The first fetch is presented one cycle after reset release.
- ISSUE:
  - ifu_valid=1; ifu_pc=pc_q, held stable until the handshake.
  - On ifu_valid && ifu_ready: go to WAIT and increment issue_cnt, which wraps modulo 2^CNT_W.
- WAIT: ifu_valid=0. On wb_valid:
  - pc_q <= trap_vec if trap_valid;
  - else wb_target if wb_redirect;
  - else pc_q + 4 (32-bit, wraps 0xFFFF_FFFC to 0x0000_0000).
  - Next state is HALT if halt, else ISSUE. The new PC appears on ifu_pc with ifu_valid=1 one cycle after wb_valid.
- Priority on simultaneous inputs: trap_valid > wb_redirect > sequential. halt is independent: pc_q still updates, then the block enters HALT.
- HALT: ifu_valid=0 permanently; all inputs ignored until reset.
- wb_valid outside WAIT: ignored. This is a protocol violation and the bench asserts it never occurs.
- ifu_ready outside ISSUE: ignored.
- Watchdog:
  - Counter increments each cycle in WAIT and clears on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0), hang <= 1. hang is sticky until reset; the FSM keeps running.
- Reset mid-operation: asynchronous return to BOOT from any state. An in-flight instruction is discarded.

Optional Feature:
- Macro: PC_GEN_MISALIGN_CHK_EN.
- Defined:
  - A redirect target with wb_target[1:0] != 0 (and no trap_valid) is not taken.
  - pc_q <= trap_vec instead, and misalign <= 1 (sticky).
- Undefined:
  - The target is loaded as-is, bits [1:0] included.
  - misalign is constant 0.

Decomposition:
- Shared package/header:
  - state encoding (BOOT=2'd0, ISSUE=2'd1, WAIT=2'd2, HALT=2'd3);
  - INST_BYTES=4;
  - default RESET_PC constant.
- One natural sub-module: pc_gen_watchdog. Inputs: clk, rst, en (state==WAIT); output: sticky hang; parameter TIMEOUT_CYCLES.

Test Plan:
- Reset release, ifu_ready=1 -> ifu_valid rises 1 cycle after reset release with ifu_pc=0x8000_0000; issue_cnt=1 after the handshake.
- Sequential commit: wb_valid alone in WAIT -> next ifu_pc=0x8000_0004 one cycle later; pc_q=0xFFFF_FFFC commits to 0x0000_0000.
- Redirect vs trap: wb_valid+wb_redirect with target 0x8000_0100 -> ifu_pc=0x8000_0100. Adding trap_valid with trap_vec 0x8000_0200 -> ifu_pc=0x8000_0200.
- Backpressure: hold ifu_ready=0 for 5 cycles in ISSUE -> ifu_valid stays 1, ifu_pc stable, issue_cnt unchanged; ready=1 -> issue_cnt +1.
- Halt and watchdog:
  - wb_valid+halt -> ifu_valid stays 0 for 100 cycles.
  - Separate run, TIMEOUT_CYCLES=16, no wb_valid -> hang=1 on the 16th WAIT cycle and stays 1.
- Macro defined: redirect target 0x8000_0102 with trap_vec 0x8000_0200 -> ifu_pc=0x8000_0200, misalign=1. Macro undefined -> ifu_pc=0x8000_0102, misalign=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and helpers for the pc_gen stage
//
// Contents: FSM state encoding, instruction size, default reset PC and the
// sequential-PC helper used by the top.
package pc_gen_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [31:0] INST_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Fall-through PC; 32-bit arithmetic, so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/pc_gen_watchdog.sv
// rtl/pc_gen_watchdog.sv - hang watchdog for the pc_gen WAIT state
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   en    in   high while the parent FSM is waiting for writeback
//   hang  out  sticky flag, set once en has been high for TIMEOUT_CYCLES
//              consecutive cycles; constant 0 when TIMEOUT_CYCLES == 0
module pc_gen_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic hang
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign hang = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          hang_q;

            // cnt is 0 during the first cycle of a wait, so cnt == LAST marks
            // the TIMEOUT_CYCLES-th waiting cycle. It saturates there; hang
            // is already sticky so there is nothing left to count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt    <= '0;
                    hang_q <= 1'b0;
                end else begin
                    if (!en)
                        cnt <= '0;
                    else if (cnt != LAST)
                        cnt <= cnt + 1'b1;
                    if (en && cnt == LAST)
                        hang_q <= 1'b1;
                end
            end

            assign hang = hang_q;
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generation stage feeding instruction fetch
//
// Optional feature macro: PC_GEN_MISALIGN_CHK_EN (misaligned redirect traps).
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   ifu_valid/ifu_ready   fetch handshake, ifu_pc is the PC offered
//   wb_valid              commit pulse for the in-flight instruction
//   wb_redirect/wb_target taken branch/jump/mret and its target
//   trap_valid/trap_vec   trap on commit and the vector to take
//   halt                  ebreak on commit; stage stops until reset
//   hang                  sticky watchdog flag
//   misalign              sticky misaligned-redirect flag
//   issue_cnt             accepted fetch handshakes, wraps
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_valid,
    input  logic             ifu_ready,
    output logic [31:0]      ifu_pc,
    input  logic             wb_valid,
    input  logic             wb_redirect,
    input  logic [31:0]      wb_target,
    input  logic             trap_valid,
    input  logic [31:0]      trap_vec,
    input  logic             halt,
    output logic             hang,
    output logic             misalign,
    output logic [CNT_W-1:0] issue_cnt
);

    logic [1:0]       state;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      next_pc;
    logic             commit;

    assign commit = (state == ST_WAIT) && wb_valid;

`ifdef PC_GEN_MISALIGN_CHK_EN
    logic bad_target;
    logic misalign_q;

    // A misaligned redirect is turned into a trap; a real trap already wins.
    assign bad_target = !trap_valid && wb_redirect && (wb_target[1:0] != 2'b00);

    always_comb begin
        next_pc = seq_pc(pc_q);
        if (trap_valid || bad_target)
            next_pc = trap_vec;
        else if (wb_redirect)
            next_pc = wb_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_q <= 1'b0;
        else if (commit && bad_target)
            misalign_q <= 1'b1;
    end

    assign misalign = misalign_q;
`else
    always_comb begin
        next_pc = seq_pc(pc_q);
        if (trap_valid)
            next_pc = trap_vec;
        else if (wb_redirect)
            next_pc = wb_target;
    end

    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_BOOT;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (ifu_ready) begin
                        state <= ST_WAIT;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        pc_q  <= next_pc;
                        state <= halt ? ST_HALT : ST_ISSUE;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign ifu_valid = (state == ST_ISSUE);
    assign ifu_pc    = pc_q;
    assign issue_cnt = cnt_q;

    pc_gen_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_WAIT),
        .hang(hang)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;

    localparam int TO = 16;
    localparam int CW = 4;
`ifdef PC_GEN_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_valid;
    logic          ifu_ready = 1'b0;
    logic [31:0]   ifu_pc;
    logic          wb_valid = 1'b0;
    logic          wb_redirect = 1'b0;
    logic [31:0]   wb_target = '0;
    logic          trap_valid = 1'b0;
    logic [31:0]   trap_vec = '0;
    logic          halt = 1'b0;
    logic          hang;
    logic          misalign;
    logic [CW-1:0] issue_cnt;

    always #5 clk = ~clk;

    pc_gen #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_pc(ifu_pc),
        .wb_valid(wb_valid), .wb_redirect(wb_redirect), .wb_target(wb_target),
        .trap_valid(trap_valid), .trap_vec(trap_vec), .halt(halt),
        .hang(hang), .misalign(misalign), .issue_cnt(issue_cnt)
    );

    // Commits only ever arrive while nothing is offered to fetch.
    always @(posedge clk)
        if (rst && wb_valid) assert (!ifu_valid);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what phase the instruction stream is in, not the FSM.
    typedef enum {BOOTING, FETCHING, EXECUTING, STOPPED} phase_t;
    phase_t      ph;
    logic [31:0] m_pc;
    int          m_issued;
    int          m_waited;
    bit          m_hang;
    bit          m_mis;

    task automatic model_edge();
        if (!rst) begin
            ph = BOOTING; m_pc = 32'h8000_0000; m_issued = 0;
            m_waited = 0; m_hang = 0; m_mis = 0;
        end else begin
            case (ph)
                BOOTING: ph = FETCHING;
                FETCHING: if (ifu_ready) begin
                    m_issued = m_issued + 1;
                    m_waited = 0;
                    ph = EXECUTING;
                end
                EXECUTING: begin
                    m_waited = m_waited + 1;
                    if (m_waited >= TO) m_hang = 1;
                    if (wb_valid) begin
                        if (trap_valid) m_pc = trap_vec;
                        else if (wb_redirect && MIS_EN && (wb_target % 4 != 0)) begin
                            m_pc = trap_vec; m_mis = 1;
                        end else if (wb_redirect) m_pc = wb_target;
                        else m_pc = m_pc + 32'd4;
                        ph = halt ? STOPPED : FETCHING;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("ifu_valid", 32'(ifu_valid), 32'(ph == FETCHING));
        if (ph == FETCHING) check("ifu_pc", ifu_pc, m_pc);
        check("hang", 32'(hang), 32'(m_hang));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("issue_cnt", 32'(issue_cnt), 32'(m_issued % (1 << CW)));
    endtask

    task automatic reset_dut();
        rst = 1'b0; ifu_ready = 0; wb_valid = 0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic handshake();
        ifu_ready = 1'b1; tick(); ifu_ready = 1'b0;
    endtask

    task automatic commit(input logic red, input logic [31:0] tgt, input logic trp,
                          input logic [31:0] vec, input logic hlt);
        wb_valid = 1; wb_redirect = red; wb_target = tgt;
        trap_valid = trp; trap_vec = vec; halt = hlt;
        tick();
        wb_valid = 0; wb_redirect = 0; trap_valid = 0; halt = 0;
    endtask

    initial begin
        #2;
        reset_dut();
        check("rst_cnt", 32'(issue_cnt), 32'd0);

        // first fetch one cycle after release
        ifu_ready = 1'b1;
        tick();
        check("boot_pc", ifu_pc, 32'h8000_0000);
        tick();
        ifu_ready = 1'b0;
        check("first_cnt", 32'(issue_cnt), 32'd1);

        commit(0, 0, 0, 0, 0);
        check("seq_pc", ifu_pc, 32'h8000_0004);
        handshake();
        commit(1, 32'h8000_0100, 0, 32'h8000_0200, 0);
        check("redir_pc", ifu_pc, 32'h8000_0100);
        handshake();
        commit(1, 32'h8000_0100, 1, 32'h8000_0200, 0);
        check("trap_pc", ifu_pc, 32'h8000_0200);
        handshake();
        commit(1, 32'hFFFF_FFFC, 0, 0, 0);
        handshake();
        commit(0, 0, 0, 0, 0);
        check("wrap_pc", ifu_pc, 32'h0000_0000);

        // backpressure
        ifu_ready = 1'b0;
        repeat (5) tick();
        check("bp_valid", 32'(ifu_valid), 32'd1);
        check("bp_pc", ifu_pc, 32'h0000_0000);
        handshake();
        check("bp_cnt", 32'(issue_cnt), 32'd6);

        commit(1, 32'h8000_0102, 0, 32'h8000_0200, 0);
        check("mis_pc", ifu_pc, MIS_EN ? 32'h8000_0200 : 32'h8000_0102);
        check("mis_flag", 32'(misalign), 32'(MIS_EN));

        // halt
        handshake();
        commit(0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            ifu_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("halt_valid", 32'(ifu_valid), 32'd0);

        // watchdog
        reset_dut();
        ifu_ready = 1'b1;
        tick(); tick();
        ifu_ready = 1'b0;
        repeat (15) tick();
        check("hang_pre", 32'(hang), 32'd0);
        tick();
        check("hang_at", 32'(hang), 32'd1);
        repeat (4) tick();
        commit(0, 0, 0, 0, 0);
        check("hang_sticky", 32'(hang), 32'd1);

        // asynchronous reset mid-flight
        handshake();
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(ifu_valid), 32'd0);
        check("arst_cnt", 32'(issue_cnt), 32'd0);
        check("arst_hang", 32'(hang), 32'd0);
        tick();
        rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int wb_den;
            wb_den = (i < 300) ? 3 : 22;
            rst = 1'b1;
            ifu_ready   = 1'($urandom_range(0, 1));
            wb_redirect = 1'($urandom_range(0, 1));
            trap_valid  = ($urandom_range(0, 3) == 0);
            halt        = ($urandom_range(0, 29) == 0);
            trap_vec    = $urandom & 32'hFFFF_FFFC;
            wb_target   = $urandom;
            if ($urandom_range(0, 3) != 0) wb_target[1:0] = 2'b00;
            wb_valid = (ph == EXECUTING) && ($urandom_range(0, wb_den) == 0);
            if (ph == STOPPED && $urandom_range(0, 9) == 0) rst = 1'b0;
            tick();
        end
        rst = 1'b1; wb_valid = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
